// File: rtl/regfile_param.sv
// Parametrised integer register file with a built-in clear sequencer and
// optional same-cycle write-to-read forwarding for the decode stage.
module regfile_param #(
    parameter int XLEN     = 32,
    parameter int NREGS    = 32,
    parameter int NREAD    = 2,
    parameter int NWRITE   = 1,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1,
    localparam int AW      = (NREGS > 1) ? $clog2(NREGS) : 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clear_req,
    output logic                   ready,
    input  logic [NWRITE-1:0]      we,
    input  logic [NWRITE*AW-1:0]   waddr,
    input  logic [NWRITE*XLEN-1:0] wdata,
    input  logic [NREAD*AW-1:0]    raddr,
    output logic [NREAD*XLEN-1:0]  rdata
);

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_e;

    state_e          state_q, state_d;
    logic [AW-1:0]   clr_idx_q, clr_idx_d;
    logic [XLEN-1:0] mem_q [NREGS];

    logic [AW-1:0]     wa [NWRITE];
    logic [XLEN-1:0]   wd [NWRITE];
    logic [NWRITE-1:0] wr_fwd;
    logic [NWRITE-1:0] wr_acc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_CLEAR;
            clr_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_idx_q <= clr_idx_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        case (state_q)
            ST_CLEAR: begin
                // clr_idx wraps to 0 naturally on the last entry
                clr_idx_d = clr_idx_q + AW'(1);
                if (clr_idx_q == AW'(NREGS - 1)) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (clear_req) begin
                    state_d = ST_CLEAR;
                end
            end
            default: begin
                state_d = ST_CLEAR;
            end
        endcase
    end

    assign ready = (state_q == ST_RUN);

    // Forwarding qualifier leaves out clear_req so rdata never depends on it;
    // the array write itself is additionally dropped on a clear request.
    always_comb begin
        for (int k = 0; k < NWRITE; k++) begin
            wa[k]     = waddr[k*AW +: AW];
            wd[k]     = wdata[k*XLEN +: XLEN];
            wr_fwd[k] = we[k] && ready && !((ZERO_REG != 0) && (wa[k] == '0));
            wr_acc[k] = wr_fwd[k] && !clear_req;
        end
    end

    always_ff @(posedge clk) begin
        if (state_q == ST_CLEAR) begin
            mem_q[clr_idx_q] <= '0;
        end else begin
            // Ascending port order: the higher port wins on an address clash
            for (int k = 0; k < NWRITE; k++) begin
                if (wr_acc[k]) begin
                    mem_q[wa[k]] <= wd[k];
                end
            end
        end
    end

    always_comb begin
        logic [AW-1:0]   ra;
        logic [XLEN-1:0] val;
        rdata = '0;
        for (int i = 0; i < NREAD; i++) begin
            ra  = raddr[i*AW +: AW];
            val = mem_q[ra];
            if (BYPASS != 0) begin
                for (int k = 0; k < NWRITE; k++) begin
                    if (wr_fwd[k] && (wa[k] == ra)) begin
                        val = wd[k];
                    end
                end
            end
            if (!ready || ((ZERO_REG != 0) && (ra == '0))) begin
                val = '0;
            end
            rdata[i*XLEN +: XLEN] = val;
        end
    end

endmodule

// File: tb/tb_regfile_param.sv
// Randomised and directed bench for regfile_param: three configurations
// (forwarding dual-write, no-forwarding single-write, small 16-bit sweep).
module tb_regfile_param;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clear_req;
    logic [1:0]  we;
    logic [9:0]  waddr;
    logic [63:0] wdata;
    logic [9:0]  raddr;
    logic        ready_a, ready_b;
    logic [63:0] rdata_a, rdata_b;

    logic        c_clear_req;
    logic [0:0]  c_we;
    logic [2:0]  c_waddr;
    logic [15:0] c_wdata;
    logic [8:0]  c_raddr;
    logic        c_ready;
    logic [47:0] c_rdata;

    int checks = 0;
    int failures = 0;

    logic [31:0] ma [32];
    logic [31:0] mb [32];
    bit          m_ready = 1'b0;
    int          m_edges = 0;

    always #5 clk = ~clk;

    regfile_param #(.XLEN(32), .NREGS(32), .NREAD(2), .NWRITE(2), .ZERO_REG(1), .BYPASS(1)) u_a (
        .clk(clk), .rst_n(rst_n), .clear_req(clear_req), .ready(ready_a),
        .we(we), .waddr(waddr), .wdata(wdata), .raddr(raddr), .rdata(rdata_a)
    );

    regfile_param #(.XLEN(32), .NREGS(32), .NREAD(2), .NWRITE(1), .ZERO_REG(1), .BYPASS(0)) u_b (
        .clk(clk), .rst_n(rst_n), .clear_req(clear_req), .ready(ready_b),
        .we(we[0:0]), .waddr(waddr[4:0]), .wdata(wdata[31:0]), .raddr(raddr), .rdata(rdata_b)
    );

    regfile_param #(.XLEN(16), .NREGS(8), .NREAD(3), .NWRITE(1), .ZERO_REG(0), .BYPASS(1)) u_c (
        .clk(clk), .rst_n(rst_n), .clear_req(c_clear_req), .ready(c_ready),
        .we(c_we), .waddr(c_waddr), .wdata(c_wdata), .raddr(c_raddr), .rdata(c_rdata)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
        end
    endtask

    // Expected reads: zero when not ready or register 0; newest write of this cycle forwarded.
    function automatic logic [31:0] exp_a(input int i);
        logic [4:0]  a;
        logic [31:0] v;
        a = raddr[i*5 +: 5];
        if (!m_ready || a == 5'd0) return 32'h0;
        v = ma[a];
        for (int k = 0; k < 2; k++)
            if (we[k] && waddr[k*5 +: 5] == a) v = wdata[k*32 +: 32];
        return v;
    endfunction

    function automatic logic [31:0] exp_b(input int i);
        logic [4:0] a;
        a = raddr[i*5 +: 5];
        if (!m_ready || a == 5'd0) return 32'h0;
        return mb[a];
    endfunction

    task automatic check_all();
        chk("ready_a", {63'd0, ready_a}, {63'd0, m_ready});
        chk("ready_b", {63'd0, ready_b}, {63'd0, m_ready});
        for (int i = 0; i < 2; i++) begin
            if (!(clear_req && m_ready))
                chk("rdata_a", {32'd0, rdata_a[i*32 +: 32]}, {32'd0, exp_a(i)});
            chk("rdata_b", {32'd0, rdata_b[i*32 +: 32]}, {32'd0, exp_b(i)});
        end
    endtask

    task automatic model_edge();
        if (!rst_n) return;
        if (!m_ready) begin
            m_edges++;
            if (m_edges == 32) begin
                m_ready = 1'b1;
                m_edges = 0;
                for (int r = 0; r < 32; r++) begin
                    ma[r] = 32'h0;
                    mb[r] = 32'h0;
                end
            end
        end else if (clear_req) begin
            m_ready = 1'b0;
            m_edges = 0;
        end else begin
            for (int k = 0; k < 2; k++)
                if (we[k] && waddr[k*5 +: 5] != 5'd0) ma[waddr[k*5 +: 5]] = wdata[k*32 +: 32];
            if (we[0] && waddr[4:0] != 5'd0) mb[waddr[4:0]] = wdata[31:0];
        end
    endtask

    task automatic cyc();
        @(negedge clk);
        check_all();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle();
        clear_req = 1'b0;
        we = 2'b00;
    endtask

    task automatic assert_reset();
        rst_n = 1'b0;
        m_ready = 1'b0;
        m_edges = 0;
        #1;
        chk("rst_async_ready", {63'd0, ready_a}, 64'd0);
    endtask

    // Edges until ready rises; 0 means it never rose within the budget.
    task automatic clr_count(output int n, output int nc);
        n = 0;
        nc = 0;
        for (int e = 1; e <= 40; e++) begin
            cyc();
            if (c_ready && nc == 0) nc = e;
            if (ready_a) begin
                n = e;
                break;
            end
        end
    endtask

    int n, nc;

    initial begin
        idle();
        waddr = '0; wdata = '0; raddr = '0;
        c_clear_req = 1'b0; c_we = 1'b0; c_waddr = '0; c_wdata = '0; c_raddr = '0;
        repeat (3) cyc();
        rst_n = 1'b1;
        clr_count(n, nc);
        chk("clear_len_32", n, 32);
        chk("clear_len_8", nc, 8);

        for (int r = 0; r < 32; r += 2) begin
            raddr = {5'(r + 1), 5'(r)};
            #1;
            chk("post_clear_zero", rdata_a, 64'd0);
            cyc();
        end

        we = 2'b01; waddr = 10'd5; wdata = 64'hDEADBEEF;
        cyc();
        idle(); raddr = {5'd0, 5'd5};
        #1;
        chk("x5_read", {32'd0, rdata_a[31:0]}, 64'hDEADBEEF);
        chk("x0_read", {32'd0, rdata_a[63:32]}, 64'd0);
        cyc();

        we = 2'b01; waddr = 10'd0; wdata = 64'h1234; raddr = 10'd0;
        cyc();
        idle();
        #1;
        chk("x0_ignores_write", {32'd0, rdata_a[31:0]}, 64'd0);
        cyc();

        we = 2'b01; waddr = 10'd7; wdata = 64'hA5A5A5A5; raddr = {5'd7, 5'd0};
        #1;
        chk("bypass_on", {32'd0, rdata_a[63:32]}, 64'hA5A5A5A5);
        chk("bypass_off_old", {32'd0, rdata_b[63:32]}, 64'd0);
        cyc();
        idle();
        #1;
        chk("nobypass_after_edge", {32'd0, rdata_b[63:32]}, 64'hA5A5A5A5);
        cyc();

        we = 2'b11; waddr = {5'd3, 5'd3}; wdata = {32'h22, 32'h11};
        cyc();
        idle(); raddr = {5'd3, 5'd3};
        #1;
        chk("port1_wins", {32'd0, rdata_a[31:0]}, 64'h22);
        cyc();

        clear_req = 1'b1; we = 2'b01; waddr = 10'd4; wdata = 64'h55;
        cyc();
        idle();
        #1;
        chk("clear_req_drops_ready", {63'd0, ready_a}, 64'd0);
        clr_count(n, nc);
        chk("clear_req_len", n, 32);
        raddr = {5'd5, 5'd4};
        #1;
        chk("x4_dropped", rdata_a, 64'd0);
        cyc();

        c_we = 1'b1; c_waddr = 3'd0; c_wdata = 16'hBEEF; c_raddr = 9'd0;
        #1;
        chk("sweep_bypass", {16'd0, c_rdata}, {16'd0, {3{16'hBEEF}}});
        cyc();
        c_we = 1'b0;
        #1;
        chk("sweep_r0_readback", {16'd0, c_rdata}, {16'd0, {3{16'hBEEF}}});
        cyc();

        for (int t = 0; t < 1500; t++) begin
            clear_req = ($urandom_range(0, 199) == 0);
            we = 2'($urandom_range(0, 3));
            waddr = 10'($urandom);
            wdata = {$urandom, $urandom};
            raddr = 10'($urandom);
            if ($urandom_range(0, 3) == 0) raddr[4:0] = waddr[4:0];
            if ($urandom_range(0, 3) == 0) raddr[9:5] = waddr[9:5];
            if ($urandom_range(0, 7) == 0) raddr[9:5] = waddr[4:0];
            cyc();
        end
        idle();

        n = 0;
        for (int e = 0; e < 40 && !ready_a; e++) cyc();
        chk("ready_before_reset", {63'd0, ready_a}, 64'd1);
        assert_reset();
        repeat (2) cyc();
        rst_n = 1'b1;
        clr_count(n, nc);
        chk("reset_clear_len", n, 32);

        clear_req = 1'b1;
        cyc();
        idle();
        repeat (10) cyc();
        assert_reset();
        cyc();
        rst_n = 1'b1;
        clr_count(n, nc);
        chk("midclear_reset_len", n, 32);
        for (int r = 0; r < 32; r += 2) begin
            raddr = {5'(r + 1), 5'(r)};
            cyc();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
